// File: rtl/perf_pkg.sv
// perf_pkg: shared types and constants for the performance counter bank.
// Build option: PERF_SAT_EN selects saturating counters instead of wrapping.
package perf_pkg;

   typedef struct packed {
      logic edge_mode;
      logic chan_en;
   } perf_cfg_t;

   localparam int CFG_EN_BIT   = 0;
   localparam int CFG_EDGE_BIT = 1;

   localparam perf_cfg_t CFG_RESET = '{edge_mode: 1'b0, chan_en: 1'b1};

   // Unpack the raw 2-bit config word into its fields.
   function automatic perf_cfg_t cfg_from_bits(input logic [1:0] bits);
      perf_cfg_t c;
      c.chan_en   = bits[CFG_EN_BIT];
      c.edge_mode = bits[CFG_EDGE_BIT];
      return c;
   endfunction

endpackage

// File: rtl/perf_chan.sv
// perf_chan: one event counter channel with config, edge history and overflow.
// Build option: PERF_SAT_EN makes the counter saturate at all-ones.
module perf_chan
   import perf_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             clear,
   input  logic             evt,
   input  logic             cfg_we,
   input  perf_cfg_t        cfg_wdata,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   perf_cfg_t        cfg;
   logic             evt_q;
   logic             hit;
   logic             inc;
   logic             at_max;
   logic [CNT_W-1:0] cnt_nxt;

   // Hit qualification and next counter value.
   always_comb begin
      hit    = cfg.edge_mode ? (evt & ~evt_q) : evt;
      inc    = run & cfg.chan_en & hit;
      at_max = &cnt;
`ifdef PERF_SAT_EN
      cnt_nxt = at_max ? cnt : cnt + CNT_W'(1);
`else
      cnt_nxt = cnt + CNT_W'(1);
`endif
   end

   // Configuration register; clear leaves it untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg <= CFG_RESET;
      end else if (cfg_we) begin
         cfg <= cfg_wdata;
      end
   end

   // Edge history follows the input every cycle so re-enable sees no edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         evt_q <= 1'b0;
      end else if (clear) begin
         evt_q <= 1'b0;
      end else begin
         evt_q <= evt;
      end
   end

   // Counter and sticky overflow; clear wins over increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clear) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (inc) begin
         cnt <= cnt_nxt;
         if (at_max) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CNT event counters with snapshot and read port.
// Build option: PERF_SAT_EN (saturating counters, see perf_chan).
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_CNT = 8,
   parameter int CNT_W   = 32,
   parameter int SEL_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               clear,
   input  logic [NUM_CNT-1:0] evt,
   input  logic               snap,
   input  logic               cfg_we,
   input  logic [SEL_W-1:0]   cfg_addr,
   input  logic [1:0]         cfg_wdata,
   input  logic               rd_en,
   input  logic [SEL_W-1:0]   rd_sel,
   output logic [CNT_W-1:0]   rdata,
   output logic               rvalid,
   output logic [NUM_CNT-1:0] ovf,
   output logic               any_ovf
);

   logic [CNT_W-1:0] live   [NUM_CNT];
   logic [CNT_W-1:0] shadow [NUM_CNT];
   logic [CNT_W-1:0] rd_mux;
   perf_cfg_t        cfg_word;

   assign cfg_word = cfg_from_bits(cfg_wdata);

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_chan
      logic chan_we;

      // Out-of-range addresses match no channel and are dropped.
      assign chan_we = cfg_we & (cfg_addr == SEL_W'(i));

      perf_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .run       (run),
         .clear     (clear),
         .evt       (evt[i]),
         .cfg_we    (chan_we),
         .cfg_wdata (cfg_word),
         .cnt       (live[i]),
         .ovf       (ovf[i])
      );
   end

   assign any_ovf = |ovf;

   // Snapshot captures pre-increment, pre-clear values of every channel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            shadow[i] <= '0;
         end
      end else if (snap) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            shadow[i] <= live[i];
         end
      end
   end

   // Read mux over the shadow bank; unmatched selects read as zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            rd_mux = shadow[i];
         end
      end
   end

   // Registered read port: data held between reads, valid pulses once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd_en;
         if (rd_en) begin
            rdata <= rd_mux;
         end
      end
   end

endmodule
